// File: rtl/aes_bist_driver.sv
// Built-in self-test sequencer: drives LFSR plaintext/key vectors into two cipher
// instances and compares their outputs. Define BIST_STOP_ON_FAIL_EN to end a run at the first mismatch.
module aes_bist_driver #(
  parameter int unsigned NUM_TESTS  = 100,
  parameter int unsigned LATENCY    = 21,
  parameter logic [127:0] STATE_SEED = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter logic [127:0] KEY_SEED   = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [127:0] state,
  output logic [127:0] key,
  input  logic [127:0] dut_out,
  input  logic [127:0] gold_out,
  output logic         busy,
  output logic         done,
  output logic         detected,
  output logic [15:0]  detect_count,
  output logic [15:0]  first_fail_idx,
  output logic [127:0] first_fail_diff
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 16;
  localparam int unsigned WW = 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TESTS - 1);
  localparam logic [WW-1:0] LAT      = WW'(LATENCY);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [DW-1:0] POLY     = DW'(128'h87);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [DW-1:0] slfsr_q, slfsr_d, klfsr_q, klfsr_d;
  logic [DW-1:0] state_q, state_d, key_q, key_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d, ffi_q, ffi_d;
  logic [DW-1:0] ffd_q, ffd_d;
  logic          det_q, det_d, busy_q, busy_d, done_q, done_d;
  logic          mismatch_c;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] cur);
    return {cur[DW-2:0], 1'b0} ^ (cur[DW-1] ? POLY : '0);
  endfunction

  // X/Z on either cipher output counts as a mismatch in simulation
  assign mismatch_c = (dut_out !== gold_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      slfsr_q <= STATE_SEED;
      klfsr_q <= KEY_SEED;
      state_q <= '0;
      key_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ffi_q   <= '0;
      ffd_q   <= '0;
      det_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      slfsr_q <= slfsr_d;
      klfsr_q <= klfsr_d;
      state_q <= state_d;
      key_q   <= key_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ffi_q   <= ffi_d;
      ffd_q   <= ffd_d;
      det_q   <= det_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    slfsr_d = slfsr_q;
    klfsr_d = klfsr_q;
    state_d = state_q;
    key_d   = key_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ffi_d   = ffi_q;
    ffd_d   = ffd_q;
    det_d   = det_q;

    unique case (fsm_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          slfsr_d = STATE_SEED;
          klfsr_d = KEY_SEED;
          idx_d   = '0;
          cnt_d   = '0;
          det_d   = 1'b0;
          ffi_d   = '0;
          ffd_d   = '0;
          fsm_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        state_d = slfsr_q;
        key_d   = klfsr_q;
        wcnt_d  = LAT;
        fsm_d   = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - WW'(1);
        if (wcnt_q == WW'(1)) fsm_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch_c) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          det_d = 1'b1;
          if (!det_q) begin
            ffi_d = idx_q;
            ffd_d = dut_out ^ gold_out;
          end
        end
        slfsr_d = lfsr_step(slfsr_q);
        klfsr_d = lfsr_step(klfsr_q);
        if (idx_q == LAST_IDX) begin
          fsm_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
          fsm_d = S_APPLY;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch_c) fsm_d = S_DONE;
`endif
      end
      default: fsm_d = S_IDLE;
    endcase

    busy_d = (fsm_d == S_APPLY) || (fsm_d == S_WAIT) || (fsm_d == S_CHECK);
    done_d = (fsm_d == S_DONE);
  end

  assign state           = state_q;
  assign key             = key_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign detected        = det_q;
  assign detect_count    = cnt_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_diff = ffd_q;

endmodule

// File: tb/tb_aes_bist_driver.sv
// Directed self-checking bench for aes_bist_driver with a behavioural cipher pair.
module tb_aes_bist_driver;

  localparam logic [127:0] SSEED = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] KSEED = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [127:0] MSB   = {1'b1, 127'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] state, key, dut_out, gold_out, first_fail_diff;
  logic         busy, done, detected;
  logic [15:0]  detect_count, first_fail_idx;

  int           mode = 0;
  logic [127:0] v5_state;
  int           n = 0;
  int           compared = 0;
  int           mismatched = 0;

  aes_bist_driver dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .key(key),
    .dut_out(dut_out), .gold_out(gold_out), .busy(busy), .done(done),
    .detected(detected), .detect_count(detect_count),
    .first_fail_idx(first_fail_idx), .first_fail_diff(first_fail_diff)
  );

  always #5 clk = ~clk;

  // Stand-in cipher pair: mode 1 flips bit 0 always, mode 2 flips the MSB on vector 5 only
  assign gold_out = state ^ {key[63:0], key[127:64]};
  assign dut_out  = gold_out ^ ((mode == 1) ? 128'h1 :
                                ((mode == 2) && (state == v5_state)) ? MSB : 128'h0);

  function automatic logic [127:0] step(input logic [127:0] x);
    return {x[126:0], 1'b0} ^ (x[127] ? 128'h87 : 128'h0);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Pulse start for one edge; n becomes 1 after the edge that samples it
  task automatic kick();
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic tick_to(input int target);
    while (n < target && !done) tick();
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    while (!done && n < 6000) tick();
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_cycles"}, 128'(n), 128'(exp_n));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    v5_state = SSEED;
    for (int i = 0; i < 5; i++) v5_state = step(v5_state);

    // Reset state
    #12;
    chk("rst_state", state, 128'h0);
    chk("rst_key", key, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_det", 128'(detected), 128'(0));
    chk("rst_cnt", 128'(detect_count), 128'(0));
    chk("rst_ffi", 128'(first_fail_idx), 128'(0));
    chk("rst_ffd", first_fail_diff, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // Run A: every vector mismatches in bit 0; vector sequence checked
    mode = 1;
    kick();
    tick();
    chk("v0_state", state, SSEED);
    chk("v0_key", key, KSEED);
    chk("v0_busy", 128'(busy), 128'(1));
`ifndef BIST_STOP_ON_FAIL_EN
    tick_to(25);
    chk("v1_state", state, step(SSEED));
    chk("v1_key", key, step(KSEED));
    wait_done("runA", 2301);
    chk("runA_cnt", 128'(detect_count), 128'(100));
`else
    wait_done("runA", 24);
    chk("runA_cnt", 128'(detect_count), 128'(1));
`endif
    chk("runA_det", 128'(detected), 128'(1));
    chk("runA_ffi", 128'(first_fail_idx), 128'(0));
    chk("runA_ffd", first_fail_diff, 128'h1);
    repeat (3) tick();
    chk("runA_hold_cnt", 128'(detected), 128'(1));
    chk("runA_hold_ffd", first_fail_diff, 128'h1);

    // Run B: clean ciphers, started from DONE, with a stray start during WAIT
    mode = 0;
    kick();
    chk("runB_clr_cnt", 128'(detect_count), 128'(0));
    chk("runB_clr_det", 128'(detected), 128'(0));
    chk("runB_clr_ffd", first_fail_diff, 128'h0);
    chk("runB_clr_done", 128'(done), 128'(0));
    tick_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_to(40);
    chk("runB_no_restart", state, step(SSEED));
    wait_done("runB", 2301);
    chk("runB_cnt", 128'(detect_count), 128'(0));
    chk("runB_det", 128'(detected), 128'(0));
    chk("runB_ffi", 128'(first_fail_idx), 128'(0));

    // Run C: single MSB mismatch on vector 5
    mode = 2;
    kick();
`ifndef BIST_STOP_ON_FAIL_EN
    wait_done("runC", 2301);
`else
    wait_done("runC", 139);
`endif
    chk("runC_cnt", 128'(detect_count), 128'(1));
    chk("runC_det", 128'(detected), 128'(1));
    chk("runC_ffi", 128'(first_fail_idx), 128'(5));
    chk("runC_ffd", first_fail_diff, MSB);

    // Run D: reset during WAIT of vector 40, then restart from seeds
    mode = 0;
    kick();
    tick_to(925);
    chk("runD_busy_pre", 128'(busy), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("runD_rst_state", state, 128'h0);
    chk("runD_rst_key", key, 128'h0);
    chk("runD_rst_busy", 128'(busy), 128'(0));
    chk("runD_rst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("runD_idle", 128'(busy), 128'(0));
    kick();
    tick();
    chk("runD_seed_state", state, SSEED);
    chk("runD_seed_key", key, KSEED);
    wait_done("runD", 2301);
    chk("runD_cnt", 128'(detect_count), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_bist_driver.md
AES_BIST_DRIVER -- requirements
Module: aes_bist_driver

Interface
REQ-001 Parameter NUM_TESTS, default 100, number of test vectors per run (1..65535).
REQ-002 Parameter LATENCY, default 21, cycles from vector apply to valid cipher outputs (1..255).
REQ-003 Parameter STATE_SEED, default 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, nonzero plaintext LFSR seed.
REQ-004 Parameter KEY_SEED, default 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, nonzero key LFSR seed.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  run request, sampled in IDLE or DONE only.
REQ-008 state  output  128  plaintext driven to both cipher instances.
REQ-009 key  output  128  key driven to both cipher instances.
REQ-010 dut_out  input  128  output of cipher under test.
REQ-011 gold_out  input  128  output of reference cipher.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  high in DONE until next start or reset.
REQ-014 detected  output  1  sticky; at least one mismatch in current run.
REQ-015 detect_count  output  16  mismatches in current run, saturating at 16'hFFFF.
REQ-016 first_fail_idx  output  16  index of first mismatching vector; 0 if none.
REQ-017 first_fail_diff  output  128  dut_out XOR gold_out at first mismatch.

Function
REQ-018 FSM states IDLE, APPLY, WAIT, CHECK, DONE; busy high in APPLY, WAIT, CHECK.
REQ-019 IDLE/DONE with start=1: reload LFSRs from seeds, clear idx, detect_count, detected, first_fail_*, go APPLY.
REQ-020 APPLY (1 cycle): register state/key from LFSRs, load wait counter with LATENCY, go WAIT.
REQ-021 WAIT: decrement counter each cycle; after exactly LATENCY cycles go CHECK.
REQ-022 CHECK (1 cycle): mismatch if dut_out !== gold_out (bitwise, X/Z counted as mismatch in simulation).
REQ-023 On mismatch: increment detect_count (saturating), set detected; if first, capture idx and XOR difference.
REQ-024 CHECK exit: step both LFSRs; if idx == NUM_TESTS-1 go DONE, else increment idx, go APPLY.
REQ-025 LFSR step: next = {cur[126:0],1'b0} ^ (cur[127] ? 128'h87 : 128'h0).
REQ-026 state/key held stable from APPLY through end of CHECK.
REQ-027 Run length start-to-done = NUM_TESTS*(LATENCY+2)+1 cycles; done rises the cycle after the last CHECK.
REQ-028 start in APPLY/WAIT/CHECK is ignored; run is not restarted.
REQ-029 Result outputs hold their values in DONE until the next start.

Reset
REQ-030 rst=1 forces IDLE immediately, regardless of state, including mid-run.
REQ-031 Reset values: state, key, detect_count, first_fail_idx, first_fail_diff = 0; busy, done, detected = 0; LFSRs = seeds.

Configuration
REQ-032 Macro BIST_STOP_ON_FAIL_EN defined: CHECK with mismatch goes directly to DONE; detect_count ends at 1.
REQ-033 Macro BIST_STOP_ON_FAIL_EN undefined: all NUM_TESTS vectors run regardless of mismatches.

Verification
REQ-034 dut_out = gold_out always, NUM_TESTS=100, LATENCY=21 -> done after 2301 cycles, detected=0, detect_count=0.
REQ-035 dut_out = gold_out ^ 128'h1 always -> detect_count=100, first_fail_idx=0, first_fail_diff=128'h1.
REQ-036 Mismatch 128'h8000...0 injected only at vector 5 -> detect_count=1, first_fail_idx=5, first_fail_diff=128'h8000...0; with BIST_STOP_ON_FAIL_EN, done 139 cycles after start.
REQ-037 First vector check: state=STATE_SEED, key=KEY_SEED; second vector equals one LFSR step of each seed.
REQ-038 rst pulse during WAIT of vector 40 -> next cycle all outputs at reset values, FSM IDLE; subsequent start begins again from seeds.
REQ-039 start pulsed during WAIT -> ignored, run completes at normal cycle count; start in DONE -> counters cleared, new run begins.
